// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions used by the instruction fetch unit:
// fetch FSM encoding, reset PC default, NOP word and the buffer entry layout.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO of {pc, instr}; head is read
// combinationally, push while full is accepted only together with a pop.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output fetch_entry_t             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_q, rd_d;
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push) wr_d = wr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage resets to NOPs so an unwritten slot never holds a stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited in-order requests to instruction
// memory, prefetch buffer towards the core, redirect flush with discard.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  output fetch_state_e dbg_state_o
);

  // Handshakes: a request issues on mem_req && mem_gnt (mem_req/mem_addr held
  // until then); an instruction transfers on instr_valid && instr_ready, with
  // instr/instr_pc held while instr_valid && !instr_ready.

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;

  logic          grant, rsp, push, pop;
  logic [CW:0]   credits;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  fetch_entry_t  fifo_head, fifo_in;

  assign grant = mem_req && mem_gnt;
  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign rsp   = mem_rvalid && (out_q != '0);
  assign pop   = instr_valid && instr_ready;
  assign push  = rsp && (disc_q == '0) && !redirect && (!fifo_full || pop);

  // A same-cycle pop frees a slot, which keeps the pipe full with DEPTH=2.
  assign credits = DEPTH_C - {1'b0, fifo_count} - {1'b0, out_q} + {{CW{1'b0}}, pop};

  assign mem_req     = (state_q == ST_FETCH) && (credits != '0);
  assign mem_addr    = pc_q;
  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? fifo_head.instr : '0;
  assign instr_pc    = instr_valid ? fifo_head.pc : '0;
  assign dbg_state_o = state_q;
  assign fifo_in     = '{pc: rsp_pc_q, instr: mem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: if (credits == '0) state_d = ST_HOLD;
      ST_HOLD:  if (credits != '0) state_d = ST_FETCH;
      default:  state_d = ST_RESET;
    endcase
    if (redirect) state_d = ST_FETCH;
  end

  always_comb begin
    out_d    = out_q + CW'(grant) - CW'(rsp);
    disc_d   = disc_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    if (redirect) begin
      // Everything still in flight after this edge, including a same-cycle
      // grant, belongs to the old stream.
      disc_d   = out_d;
      pc_d     = align_pc(redirect_pc);
      rsp_pc_d = align_pc(redirect_pc);
    end else begin
      if (rsp && (disc_q != '0)) disc_d = disc_q - 1'b1;
      if (grant) pc_d = pc_q + PC_STEP;
      if (push)  rsp_pc_d = rsp_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2: prefetch buffer entries, power of two, 2..8.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port mem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL have port mem_addr  out  32  word-aligned fetch address, valid while mem_req is high.
REQ-007 SHALL have port mem_gnt  in  1  memory accepts the request this cycle.
REQ-008 SHALL have port mem_rvalid  in  1  response data valid.
REQ-009 SHALL have port mem_rdata  in  32  response instruction word.
REQ-010 SHALL have port redirect  in  1  flush and restart fetch at redirect_pc.
REQ-011 SHALL have port redirect_pc  in  32  new fetch address.
REQ-012 SHALL have port instr_valid  out  1  instr and instr_pc hold a fetched instruction.
REQ-013 SHALL have port instr_ready  in  1  downstream processor consumes the instruction.
REQ-014 SHALL have port instr  out  32  instruction word, head of buffer.
REQ-015 SHALL have port instr_pc  out  32  address of instr.

Function
REQ-016 SHALL implement states RESET, FETCH and HOLD: RESET->FETCH on the first cycle after rst_n deasserts; FETCH->HOLD when credits reach 0; HOLD->FETCH when a credit frees; redirect goes to FETCH from any state.
REQ-017 SHALL compute credits = DEPTH - occupancy - outstanding; assert mem_req only in FETCH with credits > 0.
REQ-018 SHALL hold mem_req and mem_addr stable until mem_gnt; a request counts as issued on the mem_req && mem_gnt cycle.
REQ-019 SHALL advance fetch PC by 4 per grant, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-020 SHALL accept in-order responses, at least one cycle after grant, pushing {mem_rdata, issued address} into the FIFO buffer.
REQ-021 SHALL present the FIFO head combinationally on instr/instr_pc; pop on instr_valid && instr_ready; push and pop in the same cycle SHALL be legal at any occupancy, including full.
REQ-022 SHALL keep instr and instr_pc stable while instr_valid && !instr_ready.
REQ-023 SHALL, on redirect: empty the buffer, deassert instr_valid the next cycle, set fetch PC to {redirect_pc[31:2], 2'b00}, and mark all outstanding requests (including one granted that cycle) for discard.
REQ-024 SHALL drop discarded responses without pushing, and SHALL issue new requests immediately after redirect if credits permit (discards consume credits until returned).
REQ-025 SHALL give redirect priority over a same-cycle rvalid, pop or grant; the redirect cycle's own mem_req SHALL not carry redirect_pc.
REQ-026 SHALL sustain one instruction per cycle with zero-wait memory and DEPTH >= 2.

Reset
REQ-027 SHALL, while rst_n is low, force mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, occupancy=outstanding=discard=0, state RESET, fetch PC=RESET_PC.
REQ-028 SHALL treat reset mid-transaction as abandonment: no response arriving after reset is pushed until a new grant occurs.

Structure
REQ-029 SHALL take the state encoding, RESET_PC default and a NOP constant (32'h0000_0013) from the shared processor package.
REQ-030 SHALL place the buffer in one sub-module, fetch_fifo (DEPTH-parameterised, with push/pop/full/empty/count).

Verification
REQ-031 Reset release, zero-wait memory, instr_ready=1 -> mem_addr 0,4,8...; instr_pc 0,4,8 on consecutive cycles after 2-cycle fill latency.
REQ-032 instr_ready=0 for 10 cycles -> exactly DEPTH instructions buffered, mem_req low, instr stable; ready=1 resumes with no loss or duplication.
REQ-033 Redirect to 32'h0000_0102 with 2 responses outstanding -> both dropped; next instr_pc=32'h0000_0100.
REQ-034 Redirect coincident with rvalid and pop -> rvalid data never appears at instr; instr_valid=0 next cycle.
REQ-035 Redirect to 32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 mem_gnt withheld 5 cycles, rst_n pulsed low mid-wait -> mem_req/instr_valid low during reset; restart at RESET_PC.
